register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32 x 32-bit general-purpose register file for the datapath.
- Sits directly downstream of the 5-to-32 write-address decoder (DECODER_5_32) and consumes its one-hot output as per-register write enables.
- Two combinational read ports and one synchronous write port.
- R0 is hardwired to zero; an optional write-to-read bypass is selected by parameter.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register address width. Fixed at 5 because the decoder is 5-to-32; other values are unsupported.
- BYPASS, 1: 1 = a read of the register being written in the same cycle returns Din; 0 = it returns the stored (old) value.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Ard1  input  5  read address, port 1.
- Ard2  input  5  read address, port 2.
- Awr  input  5  write address; feeds DECODER_5_32.Addr.
- Din  input  DATA_W  write data.
- WrEn  input  1  write enable.
- Dout1  output  DATA_W  read data, port 1.
- Dout2  output  DATA_W  read data, port 2.

Behaviour:
- Reset
  - Rst=1 clears R0..R31 to 0 immediately, without waiting for Clk.
  - Dout1 and Dout2 read 0 while Rst=1, because all storage is 0.
  - Reset dominates: WrEn=1 together with Rst=1 writes nothing.
  - Releasing Rst mid-cycle: the first possible write is on the next rising edge with Rst=0.
- Write
  - Per-register enable: en[i] = Out[i] & WrEn, where Out is the DECODER_5_32 output for Awr.
  - On a rising Clk edge, R[i] <= Din when en[i]=1, for i = 1..31.
  - en[0] is ignored; R0 is never written and always reads 0.
  - Write latency: 1 edge; the new value is visible in storage after the edge.
  - At most one register changes per edge, because the decoder output is one-hot.
- Read
  - Purely combinational, zero latency: DoutN = (ArdN==0) ? 0 : R[ArdN].
  - Both ports are independent; Ard1==Ard2 is legal and both ports return the same value.
- Bypass, BYPASS=1
  - If WrEn=1 and Awr==ArdN and Awr!=0, then DoutN = Din in the same cycle (write-first).
  - The bypass is combinational only; storage still updates at the edge.
  - Active only while Rst=0.
- Bypass, BYPASS=0
  - DoutN shows the old R[ArdN] until the edge, then the new value.
- Boundaries
  - Awr=0 with WrEn=1: no state change, and no bypass on either port.
  - Awr=31: R31 is written; there is no wrap-around.
  - WrEn=0: Din and Awr are don't-care and all registers hold.
  - X or Z on Awr while WrEn=0 must not corrupt any register.
- Storage: 31 x DATA_W flops; the R0 flop is omitted.

Decomposition:
- Shared package regfile_pkg holds:
  - constant NUM_REGS=32, DATA_W=32, ADDR_W=5;
  - constant ZERO_REG=5'd0;
  - typedef reg_addr_t (5-bit);
  - typedef reg_data_t (32-bit).
- Sub-module: the existing DECODER_5_32, instantiated once for write-enable generation; it is not re-implemented.
- The read multiplexers stay in register_file; a separate read-mux module is not required.

Test Plan:
1. Assert Rst=1 mid-simulation with no Clk edge -> Dout1 = Dout2 = 32'h0 immediately, for Ard1=5 and Ard2=31 (registers previously nonzero).
2. WrEn=1, Awr=7, Din=32'hDEADBEEF, one edge; then WrEn=0, Ard1=7, Ard2=8 -> Dout1=32'hDEADBEEF, Dout2=32'h0.
3. WrEn=1, Awr=0, Din=32'hFFFFFFFF, one edge; Ard1=0 -> Dout1=32'h0 both before and after the edge, and no other register changes.
4. BYPASS=1: R3=32'h1111, then WrEn=1, Awr=3, Din=32'h2222, Ard1=Ard2=3 -> Dout1=Dout2=32'h2222 before the edge. With BYPASS=0 the same stimulus gives 32'h1111 before the edge and 32'h2222 after it.
5. Loop i=1..31: write Din=i*32'h01010101 to Ri; then read all 32 addresses on both ports -> Ri matches its written value, R0=0, no aliasing.
6. Rst=1 held asserted across an edge with WrEn=1, Awr=9, Din=32'hA5A5A5A5 -> R9=0 after Rst falls. The first write with Rst=0 on the next edge succeeds.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 32-bit general-purpose register file.
package regfile_pkg;

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;

   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/DECODER_5_32.sv
// 5-to-32 one-hot address decoder. The register file uses its output as
// per-register write enables.
module DECODER_5_32
   import regfile_pkg::*;
(
   input  reg_addr_t             Addr,
   output logic [NUM_REGS-1:0]   Out
);

   always_comb begin
      Out       = '0;
      Out[Addr] = 1'b1;
   end

endmodule

// File: rtl/register_file.sv
// 32 x DATA_W register file: two combinational read ports, one synchronous write
// port, R0 hardwired to zero, optional write-first bypass on both read ports.
module register_file
   import regfile_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [ADDR_W-1:0] Ard1,
   input  logic [ADDR_W-1:0] Ard2,
   input  logic [ADDR_W-1:0] Awr,
   input  logic [DATA_W-1:0] Din,
   input  logic              WrEn,
   output logic [DATA_W-1:0] Dout1,
   output logic [DATA_W-1:0] Dout2
);

   logic [NUM_REGS-1:0] dec_out;
   logic [NUM_REGS-1:0] wr_en;
   logic                unused_wr_en0;

   // R0 has no flop, so its slot is left out of the storage array.
   logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];

   logic byp1;
   logic byp2;

   DECODER_5_32 u_wr_dec (
      .Addr (Awr),
      .Out  (dec_out)
   );

   assign wr_en         = dec_out & {NUM_REGS{WrEn}};
   assign unused_wr_en0 = wr_en[0];

   // NOTE: this array is reset on purpose -- every register must read 0 the
   // instant Rst rises, so it cannot be inferred as an unreset RAM macro.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_en[i]) begin
               regs_q[i] <= Din;
            end
         end
      end
   end

   assign byp1 = (BYPASS != 0) && !Rst && WrEn && (Awr == Ard1) && (Awr != ZERO_REG);
   assign byp2 = (BYPASS != 0) && !Rst && WrEn && (Awr == Ard2) && (Awr != ZERO_REG);

   always_comb begin
      if (Ard1 == ZERO_REG) begin
         Dout1 = '0;
      end else if (byp1) begin
         Dout1 = Din;
      end else begin
         Dout1 = regs_q[Ard1];
      end
   end

   always_comb begin
      if (Ard2 == ZERO_REG) begin
         Dout2 = '0;
      end else if (byp2) begin
         Dout2 = Din;
      end else begin
         Dout2 = regs_q[Ard2];
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench: one register file with bypass and one without, driven by
// the same inputs and compared against an array model of the architectural state.
module tb_register_file;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [4:0]  Ard1, Ard2, Awr;
   logic [31:0] Din;
   logic        WrEn;
   logic [31:0] Dout1_b, Dout2_b, Dout1_n, Dout2_n;

   int checks   = 0;
   int failures = 0;

   logic [31:0] model [32];
   logic [31:0] act [4];
   logic [31:0] exp_v [4];

   register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
      .Clk(Clk), .Rst(Rst), .Ard1(Ard1), .Ard2(Ard2), .Awr(Awr),
      .Din(Din), .WrEn(WrEn), .Dout1(Dout1_b), .Dout2(Dout2_b)
   );

   register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nob (
      .Clk(Clk), .Rst(Rst), .Ard1(Ard1), .Ard2(Ard2), .Awr(Awr),
      .Din(Din), .WrEn(WrEn), .Dout1(Dout1_n), .Dout2(Dout2_n)
   );

   always #5 Clk = ~Clk;

   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
      if (a == 5'd0) return 32'h0;
      if (byp && !Rst && WrEn && Awr == a) return Din;
      return model[a];
   endfunction

   // Advance one rising edge and apply the architectural write rule to the model.
   task automatic tick();
      @(posedge Clk);
      #1;
      if (!Rst && WrEn === 1'b1 && Awr != 5'd0) model[Awr] = Din;
   endtask

   task automatic model_compare(input string name);
      act   = '{Dout1_b, Dout2_b, Dout1_n, Dout2_n};
      exp_v = '{exp_rd(Ard1, 1), exp_rd(Ard2, 1), exp_rd(Ard1, 0), exp_rd(Ard2, 0)};
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (act[k] !== exp_v[k]) begin
            failures++;
            $display("FAIL %s out%0d ard1=%0d ard2=%0d awr=%0d wren=%0b got=%h exp=%h",
                     name, k, Ard1, Ard2, Awr, WrEn, act[k], exp_v[k]);
         end
      end
   endtask

   task automatic test_reset();
      Rst = 1'b1; WrEn = 1'b0; Awr = 5'd0; Din = 32'h0; Ard1 = 5'd5; Ard2 = 5'd31;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      #12;
      act = '{Dout1_b, Dout2_b, Dout1_n, Dout2_n};
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (act[k] !== 32'h0) begin
            failures++;
            $display("FAIL reset_state out%0d got=%h exp=0", k, act[k]);
         end
      end
      @(negedge Clk);
      Rst = 1'b0;
   endtask

   task automatic test_write_read();
      WrEn = 1'b1; Awr = 5'd7; Din = 32'hDEADBEEF;
      tick();
      WrEn = 1'b0; Ard1 = 5'd7; Ard2 = 5'd8;
      #1;
      act = '{Dout1_b, Dout2_b, Dout1_n, Dout2_n};
      exp_v = '{32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (act[k] !== exp_v[k]) begin
            failures++;
            $display("FAIL write_read out%0d got=%h exp=%h", k, act[k], exp_v[k]);
         end
      end
   endtask

   task automatic test_r0();
      WrEn = 1'b1; Awr = 5'd0; Din = 32'hFFFFFFFF; Ard1 = 5'd0; Ard2 = 5'd0;
      #1;
      checks++;
      if (Dout1_b !== 32'h0 || Dout2_b !== 32'h0) begin
         failures++;
         $display("FAIL r0_no_bypass got=%h/%h exp=0", Dout1_b, Dout2_b);
      end
      tick();
      WrEn = 1'b0;
      for (int a = 0; a < 32; a++) begin
         Ard1 = 5'(a); Ard2 = 5'(31 - a);
         #1;
         model_compare("r0_write_ignored");
      end
      checks++;
      Ard1 = 5'd7;
      #1;
      if (Dout1_n !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL r0_r7_intact got=%h exp=deadbeef", Dout1_n);
      end
   endtask

   task automatic test_bypass();
      WrEn = 1'b1; Awr = 5'd3; Din = 32'h1111;
      tick();
      Din = 32'h2222; Ard1 = 5'd3; Ard2 = 5'd3;
      #1;
      act = '{Dout1_b, Dout2_b, Dout1_n, Dout2_n};
      exp_v = '{32'h2222, 32'h2222, 32'h1111, 32'h1111};
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (act[k] !== exp_v[k]) begin
            failures++;
            $display("FAIL bypass_pre_edge out%0d got=%h exp=%h", k, act[k], exp_v[k]);
         end
      end
      tick();
      WrEn = 1'b0;
      #1;
      act = '{Dout1_b, Dout2_b, Dout1_n, Dout2_n};
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (act[k] !== 32'h2222) begin
            failures++;
            $display("FAIL bypass_post_edge out%0d got=%h exp=2222", k, act[k]);
         end
      end
   endtask

   task automatic test_fill_all();
      for (int i = 1; i < 32; i++) begin
         WrEn = 1'b1; Awr = 5'(i); Din = i * 32'h01010101;
         tick();
      end
      WrEn = 1'b0;
      for (int a = 0; a < 32; a++) begin
         Ard1 = 5'(a); Ard2 = 5'(31 - a);
         #1;
         act   = '{Dout1_b, Dout2_b, Dout1_n, Dout2_n};
         exp_v = '{a * 32'h01010101, (31 - a) * 32'h01010101,
                   a * 32'h01010101, (31 - a) * 32'h01010101};
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (act[k] !== exp_v[k]) begin
               failures++;
               $display("FAIL fill_all addr=%0d out%0d got=%h exp=%h", a, k, act[k], exp_v[k]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      Ard1 = 5'd5; Ard2 = 5'd31; WrEn = 1'b0;
      @(posedge Clk);
      #2;
      Rst = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      act = '{Dout1_b, Dout2_b, Dout1_n, Dout2_n};
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (act[k] !== 32'h0) begin
            failures++;
            $display("FAIL async_reset out%0d got=%h exp=0", k, act[k]);
         end
      end
      // Write attempt held across an edge while reset is asserted.
      WrEn = 1'b1; Awr = 5'd9; Din = 32'hA5A5A5A5; Ard1 = 5'd9; Ard2 = 5'd9;
      #1;
      model_compare("reset_blocks_bypass");
      tick();
      model_compare("reset_blocks_write");
      #2;
      Rst = 1'b0;
      #1;
      model_compare("reset_release_r9");
      checks++;
      if (Dout1_n !== 32'h0) begin
         failures++;
         $display("FAIL reset_dominates_r9 got=%h exp=0", Dout1_n);
      end
      tick();
      WrEn = 1'b0;
      #1;
      checks++;
      if (Dout1_n !== 32'hA5A5A5A5 || Dout2_b !== 32'hA5A5A5A5) begin
         failures++;
         $display("FAIL first_write_after_reset got=%h/%h exp=a5a5a5a5", Dout1_n, Dout2_b);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         WrEn = 1'($urandom_range(0, 1));
         Awr  = 5'($urandom_range(0, 31));
         Din  = $urandom;
         Ard1 = ($urandom_range(0, 3) == 0) ? Awr : 5'($urandom_range(0, 31));
         Ard2 = ($urandom_range(0, 3) == 0) ? Awr : 5'($urandom_range(0, 31));
         if (n % 7 == 0) begin
            WrEn = 1'b0;
            Awr  = 5'bx;
         end
         #1;
         model_compare("random_pre_edge");
         tick();
      end
      WrEn = 1'b0; Awr = 5'd0;
      for (int a = 0; a < 32; a++) begin
         Ard1 = 5'(a); Ard2 = 5'(a);
         #1;
         model_compare("random_final_sweep");
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_r0();
      test_bypass();
      test_fill_all();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
